// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multicycle control FSM for the 16-bit processor datapath.
// Define MCTRL_MEM_WAIT_EN to make FETCH, MEM_RD and STORE wait for mem_ready.
module mcycle_ctrl #(
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        op,
  input  logic [3:0]        ext,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ir_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic              iord,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              pc_src,
  output logic              wb_sel,
  output logic              illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALU_WB  = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_LD_WB   = 4'd6,
    S_STORE   = 4'd7,
    S_BRANCH  = 4'd8
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STOR  = 4'b0110;
  localparam logic [3:0] OP_BZ    = 4'b1100;
  localparam logic [3:0] OP_BNZ   = 4'b1110;

  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;

  localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_AND   = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_OR    = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_XOR   = ALUOPW'(3'b100);
  localparam logic [ALUOPW-1:0] ALU_PASSB = ALUOPW'(3'b101);

  state_t state_r;
  state_t state_nxt_s;
  logic   mem_done_s;

`ifdef MCTRL_MEM_WAIT_EN
  assign mem_done_s = mem_ready;
`else
  // Memory always completes in one cycle; mem_ready is deliberately ignored.
  assign mem_done_s = 1'b1 | mem_ready;
`endif

  // State register, forced to FETCH while reset is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and output decode; every output is 0 while reset is low
  always_comb begin
    state_nxt_s = state_r;
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALU_ADD;
    pc_src      = 1'b0;
    wb_sel      = 1'b0;
    illegal     = 1'b0;
    if (reset) begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_done_s) begin
            ir_en       = 1'b1;
            pc_en       = 1'b1;
            state_nxt_s = S_DECODE;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b10;
          case (op)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI,
            OP_ORI, OP_XORI, OP_MOVI: state_nxt_s = S_EXEC;
            OP_LOAD, OP_STOR:         state_nxt_s = S_MEM_ADR;
            OP_BZ, OP_BNZ:            state_nxt_s = S_BRANCH;
            default: begin
              illegal     = 1'b1;
              state_nxt_s = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          state_nxt_s = S_ALU_WB;
          case (op)
            OP_RTYPE: begin
              alu_src_b = 2'b00;
              case (ext)
                EXT_ADD: alu_op = ALU_ADD;
                EXT_SUB: alu_op = ALU_SUB;
                EXT_AND: alu_op = ALU_AND;
                EXT_OR:  alu_op = ALU_OR;
                EXT_XOR: alu_op = ALU_XOR;
                default: begin
                  illegal     = 1'b1;
                  state_nxt_s = S_FETCH;
                end
              endcase
            end
            OP_ADDI: begin alu_src_b = 2'b10; alu_op = ALU_ADD;   end
            OP_SUBI: begin alu_src_b = 2'b10; alu_op = ALU_SUB;   end
            OP_ANDI: begin alu_src_b = 2'b11; alu_op = ALU_AND;   end
            OP_ORI:  begin alu_src_b = 2'b11; alu_op = ALU_OR;    end
            OP_XORI: begin alu_src_b = 2'b11; alu_op = ALU_XOR;   end
            OP_MOVI: begin alu_src_b = 2'b11; alu_op = ALU_PASSB; end
            default: begin
              illegal     = 1'b1;
              state_nxt_s = S_FETCH;
            end
          endcase
        end
        S_ALU_WB: begin
          reg_write   = 1'b1;
          state_nxt_s = S_FETCH;
        end
        S_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_PASSB;
          if (op == OP_STOR) begin
            state_nxt_s = S_STORE;
          end else begin
            state_nxt_s = S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_done_s) begin
            state_nxt_s = S_LD_WB;
          end else begin
            state_nxt_s = S_MEM_RD;
          end
        end
        S_LD_WB: begin
          reg_write   = 1'b1;
          wb_sel      = 1'b1;
          state_nxt_s = S_FETCH;
        end
        S_STORE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_done_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_STORE;
          end
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_op      = ALU_SUB;
          pc_src      = 1'b1;
          pc_en       = (op == OP_BZ) ? zero : ~zero;
          state_nxt_s = S_FETCH;
        end
        default: state_nxt_s = S_FETCH;
      endcase
    end else begin
      state_nxt_s = S_FETCH;
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: per-instruction expected cycle sequences are
// built from the instruction-level rules and checked by an independent monitor.
module tb_mcycle_ctrl;
  localparam int ALUOPW = 3;
  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010;
  localparam logic [2:0] A_OR = 3'b011, A_XOR = 3'b100, A_PASSB = 3'b101;

  // {pc_en, ir_en, mem_read, mem_write, iord, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, illegal}
  typedef logic [14:0] vec_t;
  typedef struct {
    logic  mr;
    logic  z;
    vec_t  e;
    string nm;
  } item_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [3:0] op, ext;
  logic pc_en, ir_en, mem_read, mem_write, iord, reg_write, alu_src_a, pc_src, wb_sel, illegal;
  logic [1:0] alu_src_b;
  logic [ALUOPW-1:0] alu_op;

  always #5 clk = ~clk;

  mcycle_ctrl #(.ALUOPW(ALUOPW)) dut (
    .clk(clk), .reset(reset), .op(op), .ext(ext), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .wb_sel(wb_sel), .illegal(illegal)
  );

  vec_t  exp_q[$];
  string nm_q[$];
  item_t seq[$];
  int checks = 0;
  int failures = 0;

  logic [4:0] imm_tbl [logic [3:0]];  // immediate opcode -> {alu_src_b, alu_op}
  logic [2:0] rfn_tbl [logic [3:0]];  // R-type ext -> alu_op
  logic [3:0] legal_ops [11] = '{4'b0000, 4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011,
                                 4'b1101, 4'b0100, 4'b0110, 4'b1100, 4'b1110};
  logic [3:0] legal_ext [5] = '{4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011};

  function automatic vec_t v(input logic [6:0] flags, input logic [1:0] sb,
                             input logic [2:0] ao, input logic [2:0] tail);
    return {flags, sb, ao, tail};
  endfunction

  task automatic check_vec(input vec_t e, input string n);
    vec_t a;
    a = {pc_en, ir_en, mem_read, mem_write, iord, reg_write, alu_src_a,
         alu_src_b, alu_op, pc_src, wb_sel, illegal};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", n, a, e);
    end
  endtask

  // Monitor: one expected vector per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    vec_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check_vec(e, n);
    end
  end

  task automatic drive(input logic rst, input logic mr, input logic z, input vec_t e, input string nm);
    reset = rst;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic mr, input logic z, input vec_t e, input string nm);
    item_t it;
    it.mr = mr;
    it.z = z;
    it.e = e;
    it.nm = nm;
    seq.push_back(it);
  endtask

  // A memory phase: optional wait cycles, then the completing cycle
  task automatic mem_phase(input vec_t busy, input vec_t done, input int waits, input string nm);
    int   w;
    logic last_mr;
    w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
`ifdef MCTRL_MEM_WAIT_EN
    last_mr = 1'b1;
`else
    w = 0;
    last_mr = 1'($urandom);
`endif
    for (int i = 0; i < w; i++) add(1'b0, 1'($urandom), busy, {nm, "_wait"});
    add(last_mr, 1'($urandom), done, nm);
  endtask

  task automatic run_instr(input logic [3:0] o, input logic [3:0] x, input int zf,
                           input int rd_waits, input int abort_at);
    string      t;
    logic [4:0] sbao;
    logic       z;
    logic       taken;
    vec_t       dec;
    vec_t       rd;
    vec_t       st;
    int         ab;
    seq.delete();
    op = o;
    ext = x;
    t = $sformatf("op%b_ext%b", o, x);
    dec = v(7'b0000000, 2'b10, A_ADD, 3'b000);
    mem_phase(v(7'b0010000, 2'b01, A_ADD, 3'b000), v(7'b1110000, 2'b01, A_ADD, 3'b000),
              -1, {t, "_fetch"});
    if (o == 4'b0000 || imm_tbl.exists(o)) begin
      add(1'($urandom), 1'($urandom), dec, {t, "_decode"});
      if (o == 4'b0000 && !rfn_tbl.exists(x)) begin
        add(1'($urandom), 1'($urandom), v(7'b0000001, 2'b00, A_ADD, 3'b001), {t, "_exec_illegal"});
      end else begin
        sbao = (o == 4'b0000) ? {2'b00, rfn_tbl[x]} : imm_tbl[o];
        add(1'($urandom), 1'($urandom), v(7'b0000001, sbao[4:3], sbao[2:0], 3'b000), {t, "_exec"});
        add(1'($urandom), 1'($urandom), v(7'b0000010, 2'b00, A_ADD, 3'b000), {t, "_alu_wb"});
      end
    end else if (o == 4'b0100 || o == 4'b0110) begin
      add(1'($urandom), 1'($urandom), dec, {t, "_decode"});
      add(1'($urandom), 1'($urandom), v(7'b0000001, 2'b00, A_PASSB, 3'b000), {t, "_mem_adr"});
      if (o == 4'b0100) begin
        rd = v(7'b0010100, 2'b00, A_ADD, 3'b000);
        mem_phase(rd, rd, rd_waits, {t, "_mem_rd"});
        add(1'($urandom), 1'($urandom), v(7'b0000010, 2'b00, A_ADD, 3'b010), {t, "_ld_wb"});
      end else begin
        st = v(7'b0001100, 2'b00, A_ADD, 3'b000);
        mem_phase(st, st, -1, {t, "_store"});
      end
    end else if (o == 4'b1100 || o == 4'b1110) begin
      add(1'($urandom), 1'($urandom), dec, {t, "_decode"});
      z = (zf < 0) ? 1'($urandom) : zf[0];
      taken = (o == 4'b1100) ? z : !z;
      add(1'($urandom), z, v({taken, 6'b000001}, 2'b00, A_SUB, 3'b100), {t, "_branch"});
    end else begin
      add(1'($urandom), 1'($urandom), v(7'b0000000, 2'b10, A_ADD, 3'b001), {t, "_decode_illegal"});
    end
    ab = (abort_at == -2) ? seq.size() - 1 : abort_at;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == ab) begin
        drive(1'b0, seq[i].mr, seq[i].z, 15'd0, {seq[i].nm, "_reset_abort"});
        break;
      end
      drive(1'b1, seq[i].mr, seq[i].z, seq[i].e, seq[i].nm);
    end
  endtask

  initial begin
    logic [3:0] ro, rx;
    int         ra;
    imm_tbl[4'b0101] = {2'b10, A_ADD};
    imm_tbl[4'b1001] = {2'b10, A_SUB};
    imm_tbl[4'b0001] = {2'b11, A_AND};
    imm_tbl[4'b0010] = {2'b11, A_OR};
    imm_tbl[4'b0011] = {2'b11, A_XOR};
    imm_tbl[4'b1101] = {2'b11, A_PASSB};
    rfn_tbl[4'b0101] = A_ADD;
    rfn_tbl[4'b1001] = A_SUB;
    rfn_tbl[4'b0001] = A_AND;
    rfn_tbl[4'b0010] = A_OR;
    rfn_tbl[4'b0011] = A_XOR;
    reset = 1'b0;
    op = 4'b0000;
    ext = 4'b0000;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 15'd0, "reset_cycle0");
    drive(1'b0, 1'b1, 1'b1, 15'd0, "reset_cycle1");
    check_vec(15'd0, "reset_state");
    run_instr(4'b0000, 4'b0101, -1, -1, -1);
    run_instr(4'b0100, 4'b0000, -1, 3, -1);
    mem_ready = 1'b0;
    #1;
`ifdef MCTRL_MEM_WAIT_EN
    check_vec(v(7'b0010000, 2'b01, A_ADD, 3'b000), "expired_wait_fetch");
`else
    check_vec(v(7'b1110000, 2'b01, A_ADD, 3'b000), "expired_wait_fetch");
`endif
    run_instr(4'b1100, 4'b0000, 1, -1, -1);
    run_instr(4'b1100, 4'b0000, 0, -1, -1);
    run_instr(4'b1110, 4'b0000, 1, -1, -1);
    run_instr(4'b1110, 4'b0000, 0, -1, -1);
    run_instr(4'b1111, 4'b0000, -1, -1, -1);
    run_instr(4'b0000, 4'b1111, -1, -1, -1);
    run_instr(4'b0110, 4'b0000, -1, -1, -2);
    run_instr(4'b0110, 4'b0000, -1, -1, -1);
    run_instr(4'b1101, 4'b0111, -1, -1, -1);
    for (int n = 0; n < 400; n++) begin
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 10)];
      rx = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ext[$urandom_range(0, 4)];
      ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ro, rx, -1, -1, ra);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
